// File: rtl/mod13_down_counter.sv
// mod13_down_counter
//   Loadable modulo down-counter. Counts from a reload value (default MAX=13)
//   down to 0. A start/stop FSM runs it. A combinational terminal-count flag
//   marks the zero cycle, and a saturating 8-bit tally counts terminal counts.
//
//   Optional feature macro: MOD13_DOWN_COUNTER_ONESHOT_EN
//     defined   : one-shot mode. tc moves to a DONE state that pulses done,
//                 then the block returns to IDLE.
//     undefined : free-running auto-reload until stop; done is tied 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   load_valid in   request to write a new reload value (IDLE only)
//   load_value in   requested reload value, clamped to MAX
//   load_ready out  high while IDLE
//   start      in   begin counting (sampled in IDLE)
//   stop       in   abort counting (sampled in RUN)
//   en         in   count enable in RUN
//   count      out  current count
//   tc         out  terminal count: RUN && en && count==0 (combinational)
//   busy       out  high whenever not IDLE
//   done       out  one-cycle registered pulse in one-shot mode
//   wrap_cnt   out  tc events since reset, saturating at 255
module mod13_down_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wrap_cnt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [7:0]       wrap_q;
  logic             load_ready_q;
  logic             busy_q;

  logic             tc_d;
  logic [WIDTH-1:0] load_clamp_d;
  logic [7:0]       wrap_inc_d;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tc_d         = (state_q == RUN) && en && (count_q == '0);
  assign load_clamp_d = clamp_load(load_value);
  assign wrap_inc_d   = sat_inc8(wrap_q);

`ifdef MOD13_DOWN_COUNTER_ONESHOT_EN
  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      // Pulse exactly for the cycle spent in DONE.
      done_q <= (state_q == RUN) && !stop && tc_d;
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= MAX_V;
      reload_q     <= MAX_V;
      wrap_q       <= 8'd0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A load in the same cycle as start takes effect, so RUN begins
          // from the freshly loaded value.
          if (load_valid) begin
            reload_q <= load_clamp_d;
            count_q  <= load_clamp_d;
          end
          if (start) begin
            state_q      <= RUN;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          // A tc coinciding with stop is still tallied.
          if (tc_d) begin
            wrap_q <= wrap_inc_d;
          end
          if (stop) begin
            state_q      <= IDLE;
            count_q      <= reload_q;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else if (tc_d) begin
`ifdef MOD13_DOWN_COUNTER_ONESHOT_EN
            state_q <= DONE;
`else
            count_q <= reload_q;
`endif
          end else if (en) begin
            // tc has priority, so count_q is nonzero here: no underflow.
            count_q <= count_q - WIDTH'(1);
          end
        end
`ifdef MOD13_DOWN_COUNTER_ONESHOT_EN
        DONE: begin
          state_q      <= IDLE;
          count_q      <= reload_q;
          load_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
`endif
        default: begin
          state_q      <= IDLE;
          count_q      <= reload_q;
          load_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign count      = count_q;
  assign tc         = tc_d;
  assign busy       = busy_q;
  assign load_ready = load_ready_q;
  assign wrap_cnt   = wrap_q;

endmodule

// File: doc/mod13_down_counter.md
# mod13_down_counter

Loadable modulo down-counter that counts from a reload value (default 13) down to 0. It is the descending counterpart to the team's 0-to-13 up-counter. A start/stop control FSM runs the counter, and a combinational terminal-count flag marks the zero cycle. The block sits beside the up-counter in the timing/sequencing datapath and supplies reload periods, terminal-count strobes and a wrap tally to downstream control logic.

## Interface
- WIDTH, 4: width of count, load_value and the reload register.
- MAX, 13: default and maximum reload value. Must satisfy MAX < 2**WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  request to write a new reload value.
- load_value  input  WIDTH  requested reload value; clamped to MAX.
- load_ready  output  1  high when a load is accepted, i.e. state IDLE.
- start  input  1  begins counting when sampled in IDLE.
- stop  input  1  aborts counting when sampled in RUN.
- en  input  1  count enable in RUN; 0 freezes the counter.
- count  output  WIDTH  current count.
- tc  output  1  terminal count, combinational: state==RUN && en && count==0.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, registered (only with the macro; tied 0 otherwise).
- wrap_cnt  output  8  number of tc events since reset, saturating at 255.

## Operation
- Reset values: state IDLE; count = MAX; reload_reg = MAX; wrap_cnt = 0; done = 0; load_ready = 1; busy = 0; tc = 0.
- IDLE:
  - load_ready = 1.
  - On load_valid: reload_reg and count both take min(load_value, MAX).
  - On start: go to RUN. If load_valid and start arrive in the same cycle, the new value loads and RUN starts from it.
  - en is ignored in IDLE.
- RUN:
  - load_ready = 0; load_valid is ignored and not queued.
  - Priority is stop > tc > decrement.
  - stop: go to IDLE, count <= reload_reg. If tc is high in the same cycle, wrap_cnt still increments.
  - tc without the macro: count <= reload_reg and wrap_cnt increments.
  - Otherwise, with en = 1: count <= count - 1.
  - en = 0: count holds and tc stays low.
- DONE (macro only): done = 1 for exactly one cycle, count = 0, busy = 1. Then go to IDLE with count <= reload_reg.
- Reload value 0: tc asserts on every enabled RUN cycle, so the period is 1 cycle.
- start while busy is ignored. stop in IDLE or DONE is ignored.
- Arithmetic: decrement never underflows because of the tc priority. wrap_cnt holds at 255.
- Asserting rst_n low at any time, including mid-RUN, applies the reset values immediately, without waiting for a clock edge.

## Timing
- start sampled at edge E0: busy = 1 and count = reload at the cycle after E0.
- With en held high and reload R, count reaches 0 R cycles later and tc is high in that cycle.
- The next edge reloads the counter (auto-reload). The period is R+1 cycles: 14 for the default.
- tc is same-cycle combinational and has no register delay.
- wrap_cnt updates on the edge that ends the tc cycle.
- Load-to-count latency is 1 edge.
- stop-to-IDLE latency is 1 edge; load_ready rises in the following cycle.
- With the macro, done is high in the cycle after tc; load_ready returns 1 the cycle after done.

## Configuration
- MOD13_DOWN_COUNTER_ONESHOT_EN
  - Defined: one-shot mode. tc in RUN transitions to DONE instead of reloading, then returns to IDLE. done is driven.
  - Undefined: free-running auto-reload until stop. The DONE state is absent and done is constant 0.

## Test plan
- Reset mid-RUN: assert rst_n = 0 with count = 7 -> count = 13, wrap_cnt = 0, busy = 0, load_ready = 1 immediately.
- Default run: start with en = 1 for 30 cycles, no macro -> count 13..0, 13..0; tc high exactly twice, 14 cycles apart; wrap_cnt = 2.
- Load and clamp:
  - load_value = 15 -> reload_reg = 13.
  - load_value = 5 with start in the same cycle -> sequence 5,4,3,2,1,0; tc on the 0 cycle.
  - load_value = 0 -> tc every cycle.
- Enable and stop:
  - en = 0 for 3 cycles at count = 9 -> count holds at 9 and tc stays 0.
  - stop at count = 0 -> IDLE, count = reload_reg, wrap_cnt incremented by 1.
  - load_valid while busy -> ignored.
- One-shot (macro defined), reload 3, en = 1 -> count 3,2,1,0; then done = 1 for one cycle; then IDLE with count = 3. A start during DONE is ignored.
- Saturation: 300 terminal counts with reload 0 -> wrap_cnt = 255 and holds.
